// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA round-trip sequencer.
// The optional per-phase timeout is enabled by defining RSA_SEQ_TIMEOUT_EN.
package rsa_pkg;

  localparam int unsigned DEFAULT_WIDTH          = 128;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1 << 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENC_INV,
    S_ENC_EXP,
    S_DEC_INV,
    S_DEC_EXP,
    S_CHECK
  } seq_state_t;

  typedef enum logic [1:0] {
    PH_RST,
    PH_GUARD,
    PH_WAIT
  } phase_t;

endpackage

// File: rtl/rsa_phase_runner.sv
// One reset-pulse / guard / wait handshake with a single RSA core phase.
// With RSA_SEQ_TIMEOUT_EN defined, WAIT is bounded by TIMEOUT_CYCLES.
module rsa_phase_runner
  import rsa_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic finish,
  output logic core_reset,
  output logic phase_done,
  output logic phase_timeout
);

  phase_t phase, phase_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase <= PH_RST;
    else     phase <= phase_nxt;
  end

  // A completed or timed-out WAIT falls straight into the next phase's RST.
  always_comb begin
    phase_nxt = PH_RST;
    if (go) begin
      case (phase)
        PH_RST:   phase_nxt = PH_GUARD;
        PH_GUARD: phase_nxt = PH_WAIT;
        PH_WAIT:  phase_nxt = (phase_done || phase_timeout) ? PH_RST : PH_WAIT;
        default:  phase_nxt = PH_RST;
      endcase
    end
  end

  assign core_reset = go && (phase == PH_RST);
  assign phase_done = go && (phase == PH_WAIT) && finish;

`ifdef RSA_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= '0;
    else if (phase == PH_RST) wait_cnt <= '0;
    else if (go && (phase == PH_WAIT) && !finish) wait_cnt <= wait_cnt + 1'b1;
  end

  assign phase_timeout = go && (phase == PH_WAIT) && !finish &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign phase_timeout = 1'b0;
`endif

endmodule

// File: rtl/rsa_roundtrip_sequencer.sv
// Drives encryptor and decryptor RSA cores through a full round trip and self-checks it.
// Define RSA_SEQ_TIMEOUT_EN to bound each WAIT by TIMEOUT_CYCLES.
module rsa_roundtrip_sequencer
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH          = DEFAULT_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   p_in,
  input  logic [WIDTH-1:0]   q_in,
  input  logic [2*WIDTH-1:0] msg_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [WIDTH-1:0]   enc_p,
  output logic [WIDTH-1:0]   enc_q,
  output logic [WIDTH-1:0]   dec_p,
  output logic [WIDTH-1:0]   dec_q,
  output logic               enc_encrypt_decrypt,
  output logic               dec_encrypt_decrypt,
  output logic [2*WIDTH-1:0] enc_msg_in,
  output logic [2*WIDTH-1:0] dec_msg_in,
  output logic               enc_reset_inverter,
  output logic               enc_reset_mod_exp,
  output logic               dec_reset_inverter,
  output logic               dec_reset_mod_exp,
  input  logic               enc_inverter_finish,
  input  logic               enc_mod_exp_finish,
  input  logic               dec_inverter_finish,
  input  logic               dec_mod_exp_finish,
  input  logic [2*WIDTH-1:0] enc_msg_out,
  input  logic [2*WIDTH-1:0] dec_msg_out
);

  seq_state_t         state, state_nxt;
  logic [WIDTH-1:0]   p_cap, q_cap;
  logic [2*WIDTH-1:0] msg_cap, cipher;
  logic               in_phase, finish_sel, core_reset, phase_done, phase_timeout, match;
  logic               accept;

  assign accept   = (state == S_IDLE) && start;
  assign in_phase = (state == S_ENC_INV) || (state == S_ENC_EXP) ||
                    (state == S_DEC_INV) || (state == S_DEC_EXP);

  always_comb begin
    finish_sel = 1'b0;
    case (state)
      S_ENC_INV: finish_sel = enc_inverter_finish;
      S_ENC_EXP: finish_sel = enc_mod_exp_finish;
      S_DEC_INV: finish_sel = dec_inverter_finish;
      S_DEC_EXP: finish_sel = dec_mod_exp_finish;
      default:   finish_sel = 1'b0;
    endcase
  end

  rsa_phase_runner #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_runner (
    .clk          (clk),
    .rst          (reset),
    .go           (in_phase),
    .finish       (finish_sel),
    .core_reset   (core_reset),
    .phase_done   (phase_done),
    .phase_timeout(phase_timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_ENC_INV;
      S_ENC_INV: if (phase_timeout) state_nxt = S_CHECK; else if (phase_done) state_nxt = S_ENC_EXP;
      S_ENC_EXP: if (phase_timeout) state_nxt = S_CHECK; else if (phase_done) state_nxt = S_DEC_INV;
      S_DEC_INV: if (phase_timeout) state_nxt = S_CHECK; else if (phase_done) state_nxt = S_DEC_EXP;
      S_DEC_EXP: if (phase_timeout || phase_done) state_nxt = S_CHECK;
      S_CHECK:   state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Verdict is registered on the final WAIT edge so it appears together with done.
  assign match = (dec_msg_out == msg_cap);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_cap   <= '0;
      q_cap   <= '0;
      msg_cap <= '0;
      cipher  <= '0;
      pass    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      if (accept) begin
        p_cap   <= p_in;
        q_cap   <= q_in;
        msg_cap <= msg_in;
        pass    <= 1'b0;
        fail    <= 1'b0;
      end
      if ((state == S_ENC_EXP) && phase_done) cipher <= enc_msg_out;
      if ((state == S_DEC_EXP) && phase_done) begin
        pass <= match;
        fail <= !match;
      end
      if (phase_timeout) begin
        pass <= 1'b0;
        fail <= 1'b1;
      end
    end
  end

`ifdef RSA_SEQ_TIMEOUT_EN
  logic timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              timeout_q <= 1'b0;
    else if (accept)        timeout_q <= 1'b0;
    else if (phase_timeout) timeout_q <= 1'b1;
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign busy = in_phase;
  assign done = (state == S_CHECK);

  assign enc_reset_inverter = core_reset && (state == S_ENC_INV);
  assign enc_reset_mod_exp  = core_reset && (state == S_ENC_EXP);
  assign dec_reset_inverter = core_reset && (state == S_DEC_INV);
  assign dec_reset_mod_exp  = core_reset && (state == S_DEC_EXP);

  assign enc_p               = p_cap;
  assign enc_q               = q_cap;
  assign dec_p               = p_cap;
  assign dec_q               = q_cap;
  assign enc_encrypt_decrypt = 1'b0;
  assign dec_encrypt_decrypt = 1'b1;
  assign enc_msg_in          = msg_cap;
  assign dec_msg_in          = cipher;

endmodule

// File: tb/tb_rsa_roundtrip_sequencer.sv
// Directed bench for rsa_roundtrip_sequencer using behavioral RSA core models.
// Timeout expectations follow whether RSA_SEQ_TIMEOUT_EN is defined.
module tb_rsa_roundtrip_sequencer;

  localparam int W = 128;
  localparam logic [2*W-1:0] KEY = {8{32'hA5C3_0F96}};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] p_in = '0, q_in = '0;
  logic [2*W-1:0] msg_in = '0;
  logic busy, done, pass, fail, timeout;
  logic [W-1:0] enc_p, enc_q, dec_p, dec_q;
  logic enc_encrypt_decrypt, dec_encrypt_decrypt;
  logic [2*W-1:0] enc_msg_in, dec_msg_in, enc_msg_out, dec_msg_out;
  logic enc_reset_inverter, enc_reset_mod_exp, dec_reset_inverter, dec_reset_mod_exp;
  logic enc_inverter_finish, enc_mod_exp_finish, dec_inverter_finish, dec_mod_exp_finish;

  // Core model controls
  logic force_fin = 1'b0, lag = 1'b0, stuck = 1'b0, corrupt = 1'b0;
  int   lat = 0;
  logic [3:0] fin = 4'hF, rd = 4'h0;
  int   cnt [4];
  logic [3:0] rs;

  int total = 0, bad = 0;
  int rst_hi [4];
  int first_rst;
  bit overlap, busy_gap;

  always #5 clk = ~clk;

  rsa_roundtrip_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .p_in(p_in), .q_in(q_in), .msg_in(msg_in),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .enc_p(enc_p), .enc_q(enc_q), .dec_p(dec_p), .dec_q(dec_q),
    .enc_encrypt_decrypt(enc_encrypt_decrypt), .dec_encrypt_decrypt(dec_encrypt_decrypt),
    .enc_msg_in(enc_msg_in), .dec_msg_in(dec_msg_in),
    .enc_reset_inverter(enc_reset_inverter), .enc_reset_mod_exp(enc_reset_mod_exp),
    .dec_reset_inverter(dec_reset_inverter), .dec_reset_mod_exp(dec_reset_mod_exp),
    .enc_inverter_finish(enc_inverter_finish), .enc_mod_exp_finish(enc_mod_exp_finish),
    .dec_inverter_finish(dec_inverter_finish), .dec_mod_exp_finish(dec_mod_exp_finish),
    .enc_msg_out(enc_msg_out), .dec_msg_out(dec_msg_out)
  );

  assign rs = {dec_reset_mod_exp, dec_reset_inverter, enc_reset_mod_exp, enc_reset_inverter};

  // Behavioral cores: finish drops on reset (optionally one cycle late), rises lat cycles later.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      rd[i] <= rs[i];
      if (lag ? rd[i] : rs[i]) begin
        fin[i] <= 1'b0;
        cnt[i] <= lat;
      end else if (cnt[i] != 0) begin
        cnt[i] <= cnt[i] - 1;
      end else begin
        fin[i] <= 1'b1;
      end
    end
  end

  assign enc_inverter_finish = force_fin | fin[0];
  assign enc_mod_exp_finish  = force_fin | fin[1];
  assign dec_inverter_finish = force_fin | fin[2];
  assign dec_mod_exp_finish  = force_fin | (fin[3] & ~stuck);
  assign enc_msg_out = enc_msg_in ^ KEY;
  assign dec_msg_out = dec_msg_in ^ KEY ^ {{(2*W-1){1'b0}}, corrupt};

  // Launches a run and samples on falling edges; n counts cycles after the accepting edge.
  task automatic run_once(input logic [W-1:0] p, input logic [W-1:0] q,
                          input logic [2*W-1:0] m, input int limit, input bit poke,
                          output int done_at);
    int n;
    @(negedge clk);
    p_in = p; q_in = q; msg_in = m; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 4; i++) rst_hi[i] = 0;
    overlap = 0; busy_gap = 0; first_rst = -1; done_at = -1; n = 0;
    while (done_at < 0 && n < limit) begin
      @(negedge clk);
      n++;
      if (poke) begin
        start = (n >= 3 && n <= 5);
        if (start) p_in = ~p;
      end
      for (int i = 0; i < 4; i++) if (rs[i]) rst_hi[i]++;
      if (rs[0] && first_rst < 0) first_rst = n;
      if ($countones(rs) > 1) overlap = 1;
      if (!done && !busy) busy_gap = 1;
      if (done) done_at = n;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy, done, pass, fail, timeout} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=00000", {busy, done, pass, fail, timeout});
    end
    total++;
    if (rs !== 4'b0) begin bad++; $display("FAIL reset_core_resets got=%b want=0000", rs); end
    total++;
    if ({enc_encrypt_decrypt, dec_encrypt_decrypt} !== 2'b01) begin
      bad++; $display("FAIL reset_mode got=%b want=01", {enc_encrypt_decrypt, dec_encrypt_decrypt});
    end
    total++;
    if (enc_p !== '0 || dec_q !== '0 || enc_msg_in !== '0 || dec_msg_in !== '0) begin
      bad++; $display("FAIL reset_captures got p=%h msg=%h want 0", enc_p, enc_msg_in);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_roundtrip();
    int d;
    logic [W-1:0] p = 128'd113680897410347;
    logic [W-1:0] q = 128'd7999808077935876437321;
    logic [2*W-1:0] m = 256'h00262d00000000000000000000000000;
    force_fin = 0; lag = 0; lat = 3;
    run_once(p, q, m, 60, 0, d);
    total++;
    if (d !== 25) begin bad++; $display("FAIL rt_done_cycle got=%0d want=25", d); end
    total++;
    if ({pass, fail, timeout} !== 3'b100) begin
      bad++; $display("FAIL rt_verdict got=%b want=100", {pass, fail, timeout});
    end
    total++;
    if (dec_msg_out !== m) begin bad++; $display("FAIL rt_dec_out got=%h want=%h", dec_msg_out, m); end
    total++;
    if (dec_msg_in !== (m ^ KEY)) begin bad++; $display("FAIL rt_cipher got=%h want=%h", dec_msg_in, m ^ KEY); end
    total++;
    if (enc_p !== p || enc_q !== q || dec_p !== p || dec_q !== q) begin
      bad++; $display("FAIL rt_primes got p=%0d q=%0d want p=%0d q=%0d", dec_p, dec_q, p, q);
    end
  endtask

  task automatic test_guard();
    int d;
    logic [W-1:0] p = 128'd8475698667747010771;
    logic [W-1:0] q = 128'd11297384090418420749;
    logic [2*W-1:0] m = 256'heb00000000;
    force_fin = 0; lag = 1; lat = 2;
    run_once(p, q, m, 60, 0, d);
    total++;
    if (d !== 25) begin bad++; $display("FAIL guard_done_cycle got=%0d want=25", d); end
    total++;
    if (rst_hi[0] !== 1 || rst_hi[1] !== 1 || rst_hi[2] !== 1 || rst_hi[3] !== 1) begin
      bad++; $display("FAIL guard_pulse_widths got=%0d,%0d,%0d,%0d want=1,1,1,1",
                      rst_hi[0], rst_hi[1], rst_hi[2], rst_hi[3]);
    end
    total++;
    if (overlap !== 0) begin bad++; $display("FAIL guard_reset_overlap got=%0d want=0", overlap); end
    total++;
    if ({pass, fail} !== 2'b10) begin bad++; $display("FAIL guard_verdict got=%b want=10", {pass, fail}); end
    lag = 0;
  endtask

  task automatic test_min_latency();
    int d;
    logic [W-1:0] p = 128'h1234_5678;
    force_fin = 1;
    run_once(p, 128'h9abc, 256'hdead_beef_0001, 40, 1, d);
    total++;
    if (d !== 13) begin bad++; $display("FAIL minlat_done_cycle got=%0d want=13", d); end
    total++;
    if (first_rst !== 1) begin bad++; $display("FAIL minlat_first_reset got=%0d want=1", first_rst); end
    total++;
    if (busy_gap !== 0) begin bad++; $display("FAIL minlat_busy_gap got=%0d want=0", busy_gap); end
    total++;
    if (enc_p !== p || pass !== 1'b1) begin
      bad++; $display("FAIL minlat_busy_start got p=%h pass=%b want p=%h pass=1", enc_p, pass, p);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL minlat_idle_after got busy=%b done=%b want 0 0", busy, done);
      end
    end
  endtask

  task automatic test_mismatch();
    int d;
    logic [2*W-1:0] m = 256'h0f0f_0000_1111;
    force_fin = 1; corrupt = 1;
    run_once(128'd7, 128'd11, m, 40, 0, d);
    total++;
    if (d !== 13) begin bad++; $display("FAIL mismatch_done_cycle got=%0d want=13", d); end
    total++;
    if ({pass, fail, timeout} !== 3'b010) begin
      bad++; $display("FAIL mismatch_verdict got=%b want=010", {pass, fail, timeout});
    end
    total++;
    if (dec_msg_in !== (m ^ KEY)) begin bad++; $display("FAIL mismatch_cipher got=%h want=%h", dec_msg_in, m ^ KEY); end
    corrupt = 0;
  endtask

  task automatic test_timeout();
    int d;
    force_fin = 0; lag = 0; lat = 0; stuck = 1;
`ifdef RSA_SEQ_TIMEOUT_EN
    run_once(128'd3, 128'd5, 256'h42, 60, 0, d);
    total++;
    if (d !== 28) begin bad++; $display("FAIL timeout_done_cycle got=%0d want=28", d); end
    total++;
    if ({pass, fail, timeout} !== 3'b011) begin
      bad++; $display("FAIL timeout_verdict got=%b want=011", {pass, fail, timeout});
    end
`else
    run_once(128'd3, 128'd5, 256'h42, 60, 0, d);
    total++;
    if (d !== -1) begin bad++; $display("FAIL nowait_bound got done at %0d want none", d); end
    total++;
    if (busy !== 1'b1 || timeout !== 1'b0) begin
      bad++; $display("FAIL nowait_busy got busy=%b timeout=%b want 1 0", busy, timeout);
    end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
`endif
    stuck = 0;
  endtask

  task automatic test_reset_midrun();
    int d;
    force_fin = 0; lag = 0; lat = 5;
    run_once(128'd13, 128'd17, 256'h77, 12, 0, d);
    total++;
    if (rst_hi[1] !== 1 || rst_hi[2] !== 0 || d !== -1) begin
      bad++; $display("FAIL midrun_position got exp_rst=%0d inv_rst=%0d done=%0d want 1 0 -1",
                      rst_hi[1], rst_hi[2], d);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, pass, fail, timeout} !== 5'b0 || rs !== 4'b0) begin
      bad++; $display("FAIL midrun_abort got flags=%b resets=%b want 0", {busy, done, pass, fail, timeout}, rs);
    end
    total++;
    if (enc_p !== '0 || enc_msg_in !== '0 || dec_msg_in !== '0) begin
      bad++; $display("FAIL midrun_captures got p=%h msg=%h want 0", enc_p, enc_msg_in);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL midrun_no_done got done=%b busy=%b want 0 0", done, busy);
    end
    @(negedge clk); reset = 1'b0;
    force_fin = 1;
    run_once(128'd19, 128'd23, 256'h99, 40, 0, d);
    total++;
    if (d !== 13 || pass !== 1'b1) begin
      bad++; $display("FAIL midrun_restart got done=%0d pass=%b want 13 1", d, pass);
    end
  endtask

  initial begin
    test_reset();
    test_roundtrip();
    test_guard();
    test_min_latency();
    test_mismatch();
    test_timeout();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
